// File: rtl/bitfusion_psum_accumulator.sv
`timescale 1ns/1ps
// Purpose: accumulates a programmable-length frame of sign/zero-extended psum beats into one wide result.
// Latency: result valid on the cycle after the last beat's accepting edge; minimum L+1 cycles per frame.
// Backpressure: psum_ready drops while a result waits in HOLD; a new frame starts the cycle after acc handshake.
//
// Ports:
//   CLK_125MHZ_FPGA  - clock, all state on rising edge
//   rst_n            - asynchronous active-low reset
//   psum/psum_signed/psum_valid/psum_ready - input beat stream (sign sampled on first beat)
//   frame_len        - beats per frame, sampled on first beat; 0 behaves as 1
//   acc_out/acc_ovf/acc_valid/acc_ready    - result port, held stable until accepted
//   busy             - frame in progress (accumulating or holding a result)
module bitfusion_psum_accumulator #(
  parameter int PSUM_W = 8,
  parameter int ACC_W  = 20,
  parameter int LEN_W  = 8
) (
  input  logic              CLK_125MHZ_FPGA,
  input  logic              rst_n,
  input  logic [PSUM_W-1:0] psum,
  input  logic              psum_signed,
  input  logic              psum_valid,
  output logic              psum_ready,
  input  logic [LEN_W-1:0]  frame_len,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              acc_ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;
  logic               psum_ready_q, psum_ready_d;
  logic               acc_valid_q, acc_valid_d;
  logic               busy_q, busy_d;

  logic               sign_eff;
  logic [ACC_W-1:0]   ext;
  logic [ACC_W:0]     sum_full;
  logic [ACC_W-1:0]   sum;
  logic               add_ovf;
  logic               beat_xfer;
  logic [LEN_W-1:0]   len_eff;
  logic [LEN_W-1:0]   cnt_inc;

  // The first beat of a frame uses the live sign; later beats use the latched one.
  assign sign_eff = (state_q == ST_IDLE) ? psum_signed : sign_q;

  assign ext = sign_eff ? {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum}
                        : {{(ACC_W-PSUM_W){1'b0}}, psum};

  // One extra bit keeps the carry-out for unsigned overflow detection.
  assign sum_full = {1'b0, acc_q} + {1'b0, ext};
  assign sum      = sum_full[ACC_W-1:0];

  // Signed: both operands share a sign but the result does not. Unsigned: carry out.
  assign add_ovf = sign_q ? ((acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]))
                          : sum_full[ACC_W];

  // Ready is a registered copy of (state != HOLD), so the transfer condition is
  // taken from the state directly to keep both views identical.
  assign beat_xfer = psum_valid && (state_q != ST_HOLD);

  assign len_eff = (frame_len == '0) ? LEN_W'(1) : frame_len;
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (beat_xfer) begin
          sign_d = psum_signed;
          len_d  = len_eff;
          acc_d  = ext;
          cnt_d  = LEN_W'(1);
          ovf_d  = 1'b0;
          state_d = (len_eff == LEN_W'(1)) ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat_xfer) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
          if (cnt_inc == len_q) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (acc_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered from the next state so they are glitch-free.
    psum_ready_d = (state_d != ST_HOLD);
    acc_valid_d  = (state_d == ST_HOLD);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_125MHZ_FPGA or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      sign_q       <= 1'b0;
      ovf_q        <= 1'b0;
      psum_ready_q <= 1'b1;
      acc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      sign_q       <= sign_d;
      ovf_q        <= ovf_d;
      psum_ready_q <= psum_ready_d;
      acc_valid_q  <= acc_valid_d;
      busy_q       <= busy_d;
    end
  end

  // acc_out keeps the last result while idle; acc_valid alone qualifies it.
  assign acc_out    = acc_q;
  assign acc_ovf    = ovf_q;
  assign acc_valid  = acc_valid_q;
  assign psum_ready = psum_ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bitfusion_psum_accumulator.sv
`timescale 1ns/1ps
module tb_bitfusion_psum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] psum;
  logic       psum_signed;
  logic       psum_valid;
  logic [7:0] frame_len;
  logic       acc_ready;

  logic        r20, v20, o20, b20;
  logic [19:0] a20;
  logic        r9, v9, o9, b9;
  logic [8:0]  a9;

  always #4 clk = ~clk;

  bitfusion_psum_accumulator #(.PSUM_W(8), .ACC_W(20), .LEN_W(8)) dut20 (
    .CLK_125MHZ_FPGA(clk), .rst_n(rst_n), .psum(psum), .psum_signed(psum_signed),
    .psum_valid(psum_valid), .psum_ready(r20), .frame_len(frame_len),
    .acc_out(a20), .acc_valid(v20), .acc_ready(acc_ready), .acc_ovf(o20), .busy(b20));

  // Narrow build shares the stimulus so overflow wrap can be observed.
  bitfusion_psum_accumulator #(.PSUM_W(8), .ACC_W(9), .LEN_W(8)) dut9 (
    .CLK_125MHZ_FPGA(clk), .rst_n(rst_n), .psum(psum), .psum_signed(psum_signed),
    .psum_valid(psum_valid), .psum_ready(r9), .frame_len(frame_len),
    .acc_out(a9), .acc_valid(v9), .acc_ready(acc_ready), .acc_ovf(o9), .busy(b9));

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // left = beats still owed in the current frame, hold = result waiting.
  typedef struct {
    int     left;
    bit     hold;
    bit     sgn;
    longint s20;
    longint s9;
    bit     f20;
    bit     f9;
  } mstate_t;

  mstate_t m;

  function automatic longint ext_val(input bit sgn, input logic [7:0] p);
    longint v;
    v = longint'(p);
    if (sgn && v >= 128) v = v - 256;
    return v;
  endfunction

  // Adds e to an accumulator kept as an unsigned residue modulo 2^w.
  function automatic void add_w(input int w, input longint acc, input longint e, input bit sgn,
                                output longint nacc, output bit ov);
    longint md, a, s;
    md = longint'(1) << w;
    if (sgn) begin
      a  = (acc >= md / 2) ? acc - md : acc;
      s  = a + e;
      ov = (s < -(md / 2)) || (s > md / 2 - 1);
    end else begin
      s  = acc + e;
      ov = (s >= md);
    end
    nacc = ((s % md) + md) % md;
  endfunction

  function automatic mstate_t model_reset();
    mstate_t n;
    n.left = 0; n.hold = 1'b0; n.sgn = 1'b0;
    n.s20 = 0; n.s9 = 0; n.f20 = 1'b0; n.f9 = 1'b0;
    return n;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input bit v, input logic [7:0] p,
                                         input bit ps, input logic [7:0] fl, input bit ar);
    mstate_t n;
    longint  e;
    bit      ov;
    n = s;
    if (s.hold) begin
      if (ar) n.hold = 1'b0;
    end else if (v) begin
      if (s.left == 0) begin
        n.sgn = ps;
        e = ext_val(ps, p);
        add_w(20, 0, e, ps, n.s20, ov);
        add_w(9, 0, e, ps, n.s9, ov);
        n.f20 = 1'b0;
        n.f9  = 1'b0;
        n.left = ((fl == 8'd0) ? 1 : int'(fl)) - 1;
      end else begin
        e = ext_val(s.sgn, p);
        add_w(20, s.s20, e, s.sgn, n.s20, ov);
        n.f20 = s.f20 | ov;
        add_w(9, s.s9, e, s.sgn, n.s9, ov);
        n.f9 = s.f9 | ov;
        n.left = s.left - 1;
      end
      if (n.left == 0) n.hold = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, psum_valid, psum, psum_signed, frame_len, acc_ready);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("psum_ready20", longint'(r20), longint'(!m.hold));
      chk("psum_ready9",  longint'(r9),  longint'(!m.hold));
      chk("acc_valid20",  longint'(v20), longint'(m.hold));
      chk("acc_valid9",   longint'(v9),  longint'(m.hold));
      chk("busy20", longint'(b20), longint'(m.hold || m.left > 0));
      chk("busy9",  longint'(b9),  longint'(m.hold || m.left > 0));
      if (m.left == 0) begin
        chk("acc_out20", longint'(a20), m.s20);
        chk("acc_out9",  longint'(a9),  m.s9);
      end
      if (m.hold) begin
        chk("acc_ovf20", longint'(o20), longint'(m.f20));
        chk("acc_ovf9",  longint'(o9),  longint'(m.f9));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] bq[$];

  // Presents one beat and returns at posedge+1 after it was accepted.
  task automatic beat(input logic [7:0] p, input bit s, input logic [7:0] fl);
    int n;
    bit r;
    n = 0;
    psum = p; psum_signed = s; frame_len = fl; psum_valid = 1'b1;
    do begin
      @(negedge clk);
      r = r20;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 100);
    if (!r) chk("beat_timeout", longint'(r), 1);
    psum_valid = 1'b0;
  endtask

  // Sends the queued beats as one frame; non-first beats carry junk sign/length
  // which must be ignored. Checks the literal result one cycle after the last beat.
  task automatic run_frame(input string nm, input bit s, input logic [7:0] fl,
                           input longint e20, input bit eo20, input longint e9, input bit eo9);
    for (int i = 0; i < bq.size(); i++) begin
      if (i == 0) beat(bq[i], s, fl);
      else        beat(bq[i], !s, 8'd1);
    end
    @(negedge clk);
    chk({nm, "_valid"}, longint'(v20), 1);
    chk({nm, "_acc20"}, longint'(a20), e20);
    chk({nm, "_ovf20"}, longint'(o20), longint'(eo20));
    chk({nm, "_acc9"},  longint'(a9),  e9);
    chk({nm, "_ovf9"},  longint'(o9),  longint'(eo9));
    @(posedge clk);
    #1;
    bq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    psum = 8'd0; psum_signed = 1'b0; psum_valid = 1'b0; frame_len = 8'd0; acc_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_acc_out", longint'(a20), 0);
    chk("rst_acc_valid", longint'(v20), 0);
    chk("rst_acc_ovf", longint'(o20), 0);
    chk("rst_busy", longint'(b20), 0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", longint'(r20), 1);

    // Unsigned 4 x 225; narrow build wraps to 388 with overflow.
    repeat (4) bq.push_back(8'd225);
    run_frame("u4", 1'b0, 8'd4, 900, 1'b0, 388, 1'b1);

    // Signed 64 - 56 - 8 = 0.
    bq.push_back(8'h40); bq.push_back(8'hC8); bq.push_back(8'hF8);
    run_frame("s3", 1'b1, 8'd3, 0, 1'b0, 0, 1'b0);

    // Signed -8 + -8 = -16.
    bq.push_back(8'hF8); bq.push_back(8'hF8);
    run_frame("s2", 1'b1, 8'd2, 20'hFFFF0, 1'b0, 9'h1F0, 1'b0);

    // frame_len 0 behaves as a single-beat frame.
    bq.push_back(8'h09);
    run_frame("len0", 1'b0, 8'd0, 9, 1'b0, 9, 1'b0);
    @(negedge clk);
    chk("busy_after_len0", longint'(b20), 0);
    @(posedge clk);
    #1;

    // Backpressure: result 3+4 held while the next beat waits.
    acc_ready = 1'b0;
    beat(8'd3, 1'b0, 8'd2);
    beat(8'd4, 1'b1, 8'd1);
    psum = 8'd10; psum_signed = 1'b0; frame_len = 8'd1; psum_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", longint'(r20), 0);
      chk("bp_valid", longint'(v20), 1);
      chk("bp_acc", longint'(a20), 7);
      @(posedge clk);
      #1;
    end
    acc_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", longint'(v20), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_next_ready", longint'(r20), 1);
    @(posedge clk);
    #1;
    psum_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", longint'(v20), 1);
    chk("bp_next_acc", longint'(a20), 10);
    @(posedge clk);
    #1;

    // 255 x 255 = 65025; narrow build wraps to 1 with overflow.
    repeat (255) bq.push_back(8'hFF);
    run_frame("u255", 1'b0, 8'd255, 65025, 1'b0, 1, 1'b1);

    // 255 + 255 fits in 9 bits; sticky overflow is cleared.
    bq.push_back(8'hFF); bq.push_back(8'hFF);
    run_frame("u2ff", 1'b0, 8'd2, 510, 1'b0, 9'h1FE, 1'b0);

    // 3 x 255 = 765 overflows the narrow build.
    repeat (3) bq.push_back(8'hFF);
    run_frame("u3ff", 1'b0, 8'd3, 765, 1'b0, 253, 1'b1);

    // Signed 3 x 127 = 381 overflows 9-bit signed range.
    repeat (3) bq.push_back(8'h7F);
    run_frame("s3pos", 1'b1, 8'd3, 381, 1'b0, 381, 1'b1);

    // Signed 3 x -128 = -384 underflows 9-bit signed range.
    repeat (3) bq.push_back(8'h80);
    run_frame("s3neg", 1'b1, 8'd3, 1048192, 1'b0, 128, 1'b1);

    // Asynchronous reset mid-frame discards the partial sum.
    beat(8'd5, 1'b0, 8'd4);
    beat(8'd6, 1'b1, 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("amid_acc_out", longint'(a20), 0);
    chk("amid_acc_valid", longint'(v20), 0);
    chk("amid_busy", longint'(b20), 0);
    chk("amid_ovf", longint'(o9), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bq.push_back(8'd1); bq.push_back(8'd2);
    run_frame("post_rst", 1'b0, 8'd2, 3, 1'b0, 3, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
